// File: rtl/ksa_shuffle_fsm.sv
// RC4 key-scheduling second loop: j += s[i] + key[i mod KEY_BYTES], swap s[i]/s[j] over a single-port S RAM.
// Optional build macro KSA_SWAP_SKIP_EN skips the read/write of s[j] when the new j equals i.
module ksa_shuffle_fsm #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic                   CLOCK_50,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [ADDR_W-1:0]      address,
  output logic [7:0]             data,
  output logic                   wren,
  input  logic [7:0]             q,
  output logic                   done,
  output logic [3:0]             state_dbg
);

  localparam int K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [ADDR_W-1:0] I_LAST = '1;

  typedef enum logic [3:0] {
    IDLE, RD_I, WAIT_I, GET_I, RD_J, WAIT_J, GET_J, WR_I, WR_J, NEXT, DONE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] i;
  logic [ADDR_W-1:0] j;
  logic [K_W-1:0]    k;
  logic [7:0]        s_i;
  logic [7:0]        s_j;
  logic [7:0]        key_byte;
  logic [ADDR_W-1:0] j_new;
  logic              busy;

  assign state_dbg = state;
  assign busy      = (state != IDLE) && (state != DONE);

  // Byte 0 of the key is its most-significant byte.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == K_W'(b)) key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  assign j_new = j + ADDR_W'(q) + ADDR_W'(key_byte);

  // Outputs are assigned on entry to a state, so they hold for that state's whole cycle.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      s_i     <= '0;
      s_j     <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      s_i     <= '0;
      s_j     <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      done    <= 1'b0;
    end else if (busy && !start) begin
      // Abort: a pending WR_J is dropped; the controller re-initialises S before retrying.
      state   <= IDLE;
      wren    <= 1'b0;
      address <= '0;
    end else begin
      case (state)
        IDLE: begin
          i       <= '0;
          j       <= '0;
          k       <= '0;
          address <= '0;
          wren    <= 1'b0;
          done    <= 1'b0;
          if (start) state <= RD_I;
        end
        RD_I:   state <= WAIT_I;
        WAIT_I: state <= GET_I;
        GET_I: begin
          s_i <= q;
          j   <= j_new;
`ifdef KSA_SWAP_SKIP_EN
          if (j_new == i) begin
            state <= NEXT;
          end else begin
            state   <= RD_J;
            address <= j_new;
          end
`else
          state   <= RD_J;
          address <= j_new;
`endif
        end
        RD_J:   state <= WAIT_J;
        WAIT_J: state <= GET_J;
        GET_J: begin
          s_j     <= q;
          state   <= WR_I;
          address <= i;
          data    <= q;
          wren    <= 1'b1;
        end
        WR_I: begin
          state   <= WR_J;
          address <= j;
          data    <= s_i;
          wren    <= 1'b1;
        end
        WR_J: begin
          state <= NEXT;
          wren  <= 1'b0;
        end
        NEXT: begin
          wren <= 1'b0;
          if (i == I_LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            i       <= i + 1'b1;
            k       <= (k == K_W'(KEY_BYTES-1)) ? '0 : k + 1'b1;
            address <= i + 1'b1;
            state   <= RD_I;
          end
        end
        DONE: begin
          if (!start) begin
            state <= IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_shuffle_fsm.sv
// Bench for ksa_shuffle_fsm: S RAM model with one wait state, RC4 KSA reference model, write and result scoreboards.
module tb_ksa_shuffle_fsm;

  logic        CLOCK_50;
  logic        reset_n;
  logic        clear;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic [7:0]  q;
  logic        done;
  logic [3:0]  state_dbg;

  ksa_shuffle_fsm #(.KEY_BYTES(3), .ADDR_W(8)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset_n   (reset_n),
    .clear     (clear),
    .start     (start),
    .secret_key(secret_key),
    .address   (address),
    .data      (data),
    .wren      (wren),
    .q         (q),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock / reset, cycle counter
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // S RAM: address registered, output registered -> data two cycles after address
  logic [7:0] mem [256];
  logic [7:0] rd1;
  always @(posedge CLOCK_50) begin
    if (wren) mem[address] <= data;
    rd1 <= mem[address];
    q   <= rd1;
  end

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_mem_q[$];
  int          exp_cyc_q[$];
  int          start_cyc_q[$];
  logic [15:0] act_wr_q[$];
  int          wr_cnt = 0;
  int          last_run_cycles = 0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flush_exp();
    exp_wr_q.delete();
    exp_mem_q.delete();
    exp_cyc_q.delete();
    start_cyc_q.delete();
  endtask

  // Reference model: plain RC4 KSA loop on an identity-initialised array.
  task automatic model_run(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] kb;
    logic [7:0] t;
    int jj;
    int cycles;
    bit skip;
    jj = 0;
    cycles = 1;
    for (int n = 0; n < 256; n++) s[n] = 8'(n);
    for (int ii = 0; ii < 256; ii++) begin
      kb = key[8*(2 - (ii % 3)) +: 8];
      jj = (jj + int'(s[ii]) + int'(kb)) % 256;
      skip = 1'b0;
`ifdef KSA_SWAP_SKIP_EN
      skip = (jj == ii);
`endif
      if (skip) begin
        cycles += 4;
      end else begin
        cycles += 9;
        exp_wr_q.push_back({8'(ii), s[jj]});
        exp_wr_q.push_back({8'(jj), s[ii]});
      end
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
    end
    for (int n = 0; n < 256; n++) exp_mem_q.push_back(s[n]);
    exp_cyc_q.push_back(cycles);
  endtask

  // Monitor: write stream
  always @(negedge CLOCK_50) begin
    if (reset_n && wren) begin
      wr_cnt = wr_cnt + 1;
      act_wr_q.push_back({address, data});
      if (exp_wr_q.size() == 0) chk("unexpected_write", {address, data}, 16'hxxxx);
      else chk("write_addr_data", {16'h0, address, data}, {16'h0, exp_wr_q.pop_front()});
    end
  end

  // Monitor: completion, run length and final memory
  always @(negedge CLOCK_50) begin
    if (reset_n && done && !prev_done) begin
      if (exp_cyc_q.size() == 0 || start_cyc_q.size() == 0) begin
        chk("done_without_run", 32'd1, 32'd0);
      end else begin
        int ec, sc;
        ec = exp_cyc_q.pop_front();
        sc = start_cyc_q.pop_front();
        last_run_cycles = cyc - sc + 1;
        chk("run_cycles", last_run_cycles, ec);
        for (int n = 0; n < 256; n++) begin
          chk($sformatf("final_mem[%0d]", n), {24'h0, mem[n]}, {24'h0, exp_mem_q.pop_front()});
        end
      end
    end
    prev_done = reset_n ? done : 1'b0;
  end

  // Driver tasks
  task automatic begin_run(input logic [23:0] key);
    for (int n = 0; n < 256; n++) mem[n] = 8'(n);
    secret_key = key;
    model_run(key);
    @(negedge CLOCK_50);
    #1;
    start_cyc_q.push_back(cyc + 1);
    start = 1'b1;
  endtask

  task automatic finish_run();
    int hold;
    for (int c = 0; c < 6000 && !done; c++) @(negedge CLOCK_50);
    chk("done_within_budget", done, 1'b1);
    hold = $urandom_range(1, 20);
    repeat (hold) begin
      @(negedge CLOCK_50);
      chk("done_held", done, 1'b1);
    end
    #1 start = 1'b0;
    @(negedge CLOCK_50);
    chk("done_dropped", done, 1'b0);
  endtask

  task automatic wait_writes(input int lim, input bit want_wr_i, output bit found);
    found = 1'b0;
    for (int c = 0; c < 5000 && !found; c++) begin
      @(negedge CLOCK_50);
      #1;
      if (wr_cnt >= lim && (!want_wr_i || (wren && wr_cnt[0]))) found = 1'b1;
    end
  endtask

  initial begin
    bit found;
    reset_n = 1'b0;
    clear = 1'b0;
    start = 1'b0;
    secret_key = '0;
    for (int n = 0; n < 256; n++) mem[n] = 8'(n);
    #25;
    chk("reset_address", {24'h0, address}, 32'h0);
    chk("reset_data", {24'h0, data}, 32'h0);
    chk("reset_wren", wren, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge CLOCK_50);
    #1 reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    // Zero key: first iterations leave s unchanged until i=2 swaps with j=3
    act_wr_q.delete();
    begin_run(24'h000000);
    finish_run();
`ifdef KSA_SWAP_SKIP_EN
    if (act_wr_q.size() >= 2) begin
      chk("key0_first_write", act_wr_q[0], {8'd2, 8'd3});
      chk("key0_second_write", act_wr_q[1], {8'd3, 8'd2});
    end else chk("key0_write_count", act_wr_q.size(), 2);
`else
    if (act_wr_q.size() >= 6) begin
      chk("key0_iter0_write", act_wr_q[0], {8'd0, 8'd0});
      chk("key0_iter1_write", act_wr_q[2], {8'd1, 8'd1});
      chk("key0_iter2_wr_i", act_wr_q[4], {8'd2, 8'd3});
      chk("key0_iter2_wr_j", act_wr_q[5], {8'd3, 8'd2});
    end else chk("key0_write_count", act_wr_q.size(), 6);
    chk("key0_done_latency", last_run_cycles, 2305);
`endif

    begin_run(24'h000249);
    finish_run();

    repeat (2) begin
      begin_run(24'($urandom()));
      finish_run();
    end

    // Asynchronous reset around iteration 100
    begin_run(24'($urandom()));
    wait_writes(200, 1'b0, found);
    chk("reset_window_found", found, 1'b1);
    repeat ($urandom_range(0, 8)) @(negedge CLOCK_50);
    #3 reset_n = 1'b0;
    #1;
    chk("async_reset_wren", wren, 1'b0);
    chk("async_reset_done", done, 1'b0);
    chk("async_reset_address", {24'h0, address}, 32'h0);
    flush_exp();
    start = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #1 reset_n = 1'b1;
    begin_run(24'($urandom()));
    finish_run();

    // Synchronous clear during WR_I
    begin_run(24'($urandom()));
    wait_writes(2 * $urandom_range(10, 200), 1'b1, found);
    chk("clear_window_found", found, 1'b1);
    clear = 1'b1;
    start = 1'b0;
    flush_exp();
    @(negedge CLOCK_50);
    chk("clear_wren", wren, 1'b0);
    chk("clear_address", {24'h0, address}, 32'h0);
    chk("clear_done", done, 1'b0);
    #1 clear = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    begin_run(24'($urandom()));
    finish_run();

    // start dropped around iteration 50
    begin_run(24'($urandom()));
    wait_writes(100, 1'b0, found);
    chk("abort_window_found", found, 1'b1);
    repeat ($urandom_range(0, 8)) @(negedge CLOCK_50);
    #1 start = 1'b0;
    flush_exp();
    @(negedge CLOCK_50);
    chk("abort_wren", wren, 1'b0);
    chk("abort_address", {24'h0, address}, 32'h0);
    repeat (300) @(negedge CLOCK_50);
    chk("abort_no_done", done, 1'b0);
    begin_run(24'($urandom()));
    finish_run();

    chk("write_queue_drained", exp_wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
